// File: rtl/note_hit_detector_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : note_pkg                                                        |
// | Purpose  : Shared constants, types and helpers for the note hit detector.  |
// |            Provides the lane_idx width, the target-line/window defaults,   |
// |            a lane-slice base helper and a small popcount used by the       |
// |            hit/streak counters.                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package note_pkg;

  // Upper bound on lanes; lane_idx is sized to address all of them.
  localparam int unsigned c_max_lanes   = 8;
  localparam int unsigned c_lane_idx_w  = 3;

  // Default target-line row and inclusive half-window, in pixels.
  localparam int unsigned c_hit_line_def = 400;
  localparam int unsigned c_hit_win_def  = 16;

  typedef logic [c_lane_idx_w-1:0] lane_idx_t;

  // LSB position of lane 'lane' in a flat bus whose per-lane field is 'width' bits.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  // Number of set bits in an up-to-8-lane vector (callers zero-extend).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage : note_pkg
`default_nettype wire

// File: rtl/note_hit_detector_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : note_hit_detector_if                                            |
// | Purpose  : Bundles the pixel, note-table, strum and result signals of the  |
// |            note hit detector.                                              |
// |   master : drives pix_valid, curr_x, curr_y, note_x, note_y, note_width,   |
// |            note_active, strum; observes all results                        |
// |   slave  : the detector; consumes the above and drives pix_valid_out,      |
// |            in_note, any_in_note, lane_idx, hit_pulse, miss_pulse, streak,  |
// |            hit_count                                                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface note_hit_detector_if
  import note_pkg::*;
#(
  parameter int LANES    = 5,
  parameter int X_W      = 10,
  parameter int PY_W     = 9,
  parameter int NY_W     = 21,
  parameter int SZ_W     = 7,
  parameter int STREAK_W = 8,
  parameter int CNT_W    = 16
);

  // Pixel stream and note table
  logic                   pix_valid;
  logic [X_W-1:0]         curr_x;
  logic [PY_W-1:0]        curr_y;
  logic [LANES*X_W-1:0]   note_x;
  logic [LANES*NY_W-1:0]  note_y;
  logic [LANES*SZ_W-1:0]  note_width;
  logic [LANES-1:0]       note_active;
  logic [LANES-1:0]       strum;

  // Results
  logic                   pix_valid_out;
  logic [LANES-1:0]       in_note;
  logic                   any_in_note;
  lane_idx_t              lane_idx;
  logic [LANES-1:0]       hit_pulse;
  logic [LANES-1:0]       miss_pulse;
  logic [STREAK_W-1:0]    streak;
  logic [CNT_W-1:0]       hit_count;

  modport master (
    output pix_valid, curr_x, curr_y, note_x, note_y, note_width, note_active, strum,
    input  pix_valid_out, in_note, any_in_note, lane_idx, hit_pulse, miss_pulse,
           streak, hit_count
  );

  modport slave (
    input  pix_valid, curr_x, curr_y, note_x, note_y, note_width, note_active, strum,
    output pix_valid_out, in_note, any_in_note, lane_idx, hit_pulse, miss_pulse,
           streak, hit_count
  );

endinterface : note_hit_detector_if
`default_nettype wire

// File: rtl/note_hit_detector_lane_bounds.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : lane_bounds                                                     |
// | Purpose  : Purely combinational per-lane tests for one falling note.       |
// |            o_inside    : pixel strictly inside the square note and the     |
// |                          lane is active.                                   |
// |            o_hit_ok    : lane is active and the note centre row lies       |
// |                          within +/-HIT_WIN of HIT_LINE (inclusive).        |
// |   Inputs : i_curr_x, i_curr_y (pixel), i_note_x, i_ny (integer note row),  |
// |            i_width, i_active                                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module lane_bounds
  import note_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int PY_W     = 9,
  parameter int SZ_W     = 7,
  parameter int HIT_LINE = c_hit_line_def,
  parameter int HIT_WIN  = c_hit_win_def
) (
  input  logic [X_W-1:0]  i_curr_x,
  input  logic [PY_W-1:0] i_curr_y,
  input  logic [X_W-1:0]  i_note_x,
  input  logic [PY_W-1:0] i_ny,
  input  logic [SZ_W-1:0] i_width,
  input  logic            i_active,
  output logic            o_inside,
  output logic            o_hit_ok
);

  localparam logic [PY_W:0] c_line = (PY_W+1)'(HIT_LINE);
  localparam logic [PY_W:0] c_win  = (PY_W+1)'(HIT_WIN);

  // Far edges carry one extra bit so a note near the right/bottom border
  // clips instead of wrapping round to column/row 0.
  logic [X_W:0]  w_x_end;
  logic [PY_W:0] w_y_end;
  logic          w_x_in;
  logic          w_y_in;

  assign w_x_end = {1'b0, i_note_x} + (X_W+1)'(i_width);
  assign w_y_end = {1'b0, i_ny}     + (PY_W+1)'(i_width);

  // Strict on both sides: the note's edge pixels are not part of it.
  assign w_x_in = (i_curr_x > i_note_x) && ({1'b0, i_curr_x} < w_x_end);
  assign w_y_in = (i_curr_y > i_ny)     && ({1'b0, i_curr_y} < w_y_end);

  assign o_inside = i_active && w_x_in && w_y_in;

  // Note centre row and its absolute distance from the target line.
  logic [PY_W:0] w_centre;
  logic [PY_W:0] w_dist;

  assign w_centre = {1'b0, i_ny} + (PY_W+1)'(i_width >> 1);
  assign w_dist   = (w_centre >= c_line) ? (w_centre - c_line) : (c_line - w_centre);

  assign o_hit_ok = i_active && (w_dist <= c_win);

endmodule : lane_bounds
`default_nettype wire

// File: rtl/note_hit_detector.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : note_hit_detector                                               |
// | Purpose  : Multi-lane note coverage test for the VGA colour mux plus strum |
// |            judging with streak and total-hit counters.                     |
// |            Pixel path: 2-stage pipeline, one pixel per clock, no stall.    |
// |            Judge path: hit/miss pulses one clock after each strum.         |
// |   clock  : system clock                                                    |
// |   reset  : asynchronous, active-high; clears pipeline and counters         |
// |   bus    : note_hit_detector_if.slave (pixel/note/strum in, results out)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module note_hit_detector
  import note_pkg::*;
#(
  parameter int LANES    = 5,
  parameter int X_W      = 10,
  parameter int PY_W     = 9,
  parameter int NY_W     = 21,
  parameter int SZ_W     = 7,
  parameter int HIT_LINE = c_hit_line_def,
  parameter int HIT_WIN  = c_hit_win_def,
  parameter int STREAK_W = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  note_hit_detector_if.slave  bus
);

  localparam int c_frac_w = NY_W - PY_W;

  // ---------------------------------------------------------------------------
  // Per-lane combinational tests
  // ---------------------------------------------------------------------------
  logic [LANES-1:0]          w_inside;
  logic [LANES-1:0]          w_hit_ok;
  logic [LANES*c_frac_w-1:0] w_unused_frac;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lane_bounds #(
      .X_W      (X_W),
      .PY_W     (PY_W),
      .SZ_W     (SZ_W),
      .HIT_LINE (HIT_LINE),
      .HIT_WIN  (HIT_WIN)
    ) u_lane_bounds (
      .i_curr_x    (bus.curr_x),
      .i_curr_y    (bus.curr_y),
      .i_note_x    (bus.note_x[lane_lsb(gi, X_W) +: X_W]),
      // Only the integer part of the fixed-point note row is compared.
      .i_ny        (bus.note_y[lane_lsb(gi, NY_W) + c_frac_w +: PY_W]),
      .i_width     (bus.note_width[lane_lsb(gi, SZ_W) +: SZ_W]),
      .i_active    (bus.note_active[gi]),
      .o_inside    (w_inside[gi]),
      .o_hit_ok    (w_hit_ok[gi])
    );

    // Sub-pixel bits only matter to the note animator upstream.
    assign w_unused_frac[gi*c_frac_w +: c_frac_w] = bus.note_y[lane_lsb(gi, NY_W) +: c_frac_w];
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
  logic             r_s1_valid;
  logic [LANES-1:0] r_s1_inside;
  logic             r_s2_valid;
  logic [LANES-1:0] r_s2_in_note;
  logic             r_s2_any;
  lane_idx_t        r_s2_lane_idx;
  lane_idx_t        w_lane_idx;

  // Lowest set lane wins; scanning downward lets the last match be the lowest.
  always_comb begin
    w_lane_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (r_s1_inside[i]) begin
        w_lane_idx = lane_idx_t'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_inside   <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_in_note  <= '0;
      r_s2_any      <= 1'b0;
      r_s2_lane_idx <= '0;
    end else begin
      r_s1_valid    <= bus.pix_valid;
      // Bubbles carry all-zero coverage so stage 2 needs no extra gating.
      r_s1_inside   <= bus.pix_valid ? w_inside : '0;
      r_s2_valid    <= r_s1_valid;
      r_s2_in_note  <= r_s1_inside;
      r_s2_any      <= |r_s1_inside;
      r_s2_lane_idx <= w_lane_idx;
    end
  end

  assign bus.pix_valid_out = r_s2_valid;
  assign bus.in_note       = r_s2_in_note;
  assign bus.any_in_note   = r_s2_any;
  assign bus.lane_idx      = r_s2_lane_idx;

  // ---------------------------------------------------------------------------
  // Strum judging and counters
  // ---------------------------------------------------------------------------
  logic [LANES-1:0]    w_hit_now;
  logic [LANES-1:0]    w_miss_now;
  logic [3:0]          w_hit_pop;
  logic [STREAK_W:0]   w_streak_sum;
  logic [CNT_W:0]      w_count_sum;
  logic [STREAK_W-1:0] w_streak_next;
  logic [CNT_W-1:0]    w_count_next;

  logic [LANES-1:0]    r_hit_pulse;
  logic [LANES-1:0]    r_miss_pulse;
  logic [STREAK_W-1:0] r_streak;
  logic [CNT_W-1:0]    r_hit_count;

  // A strum on an inactive lane fails w_hit_ok and is therefore a miss.
  assign w_hit_now  = bus.strum &  w_hit_ok;
  assign w_miss_now = bus.strum & ~w_hit_ok;
  assign w_hit_pop  = popcount8(8'(w_hit_now));

  // Sums carry one extra bit; a set MSB means the add overflowed -> saturate.
  assign w_streak_sum = (STREAK_W+1)'(r_streak)    + (STREAK_W+1)'(w_hit_pop);
  assign w_count_sum  = (CNT_W+1)'(r_hit_count)    + (CNT_W+1)'(w_hit_pop);

  always_comb begin
    w_streak_next = w_streak_sum[STREAK_W-1:0];
    if (w_streak_sum[STREAK_W]) begin
      w_streak_next = '1;
    end
    // Any miss breaks the streak; same-cycle hits do not restart it.
    if (|w_miss_now) begin
      w_streak_next = '0;
    end
  end

  always_comb begin
    w_count_next = w_count_sum[CNT_W-1:0];
    if (w_count_sum[CNT_W]) begin
      w_count_next = '1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hit_pulse  <= '0;
      r_miss_pulse <= '0;
      r_streak     <= '0;
      r_hit_count  <= '0;
    end else begin
      r_hit_pulse  <= w_hit_now;
      r_miss_pulse <= w_miss_now;
      r_streak     <= w_streak_next;
      r_hit_count  <= w_count_next;
    end
  end

  assign bus.hit_pulse  = r_hit_pulse;
  assign bus.miss_pulse = r_miss_pulse;
  assign bus.streak     = r_streak;
  assign bus.hit_count  = r_hit_count;

endmodule : note_hit_detector
`default_nettype wire

// File: tb/tb_note_hit_detector.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_note_hit_detector                                            |
// | Purpose  : Scoreboard bench for note_hit_detector. Directed stimulus       |
// |            pushes hand-computed expectations (with the cycle they are due) |
// |            into queues; a negedge monitor pops and compares whenever the   |
// |            DUT presents a pixel result or a hit/miss pulse.                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_note_hit_detector;
  import note_pkg::*;

  localparam int LANES    = 5;
  localparam int X_W      = 10;
  localparam int PY_W     = 9;
  localparam int NY_W     = 21;
  localparam int SZ_W     = 7;
  localparam int STREAK_W = 8;
  localparam int CNT_W    = 16;

  typedef struct {
    logic [LANES-1:0] in_note;
    logic             any;
    logic [2:0]       idx;
    int               due;
  } pix_exp_t;

  typedef struct {
    logic [LANES-1:0]    hit;
    logic [LANES-1:0]    miss;
    logic [STREAK_W-1:0] streak;
    logic [CNT_W-1:0]    cnt;
    int                  due;
  } jud_exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   vecs  = 0;
  int   errs  = 0;

  pix_exp_t pix_q[$];
  jud_exp_t jud_q[$];

  note_hit_detector_if #(
    .LANES(LANES), .X_W(X_W), .PY_W(PY_W), .NY_W(NY_W),
    .SZ_W(SZ_W), .STREAK_W(STREAK_W), .CNT_W(CNT_W)
  ) bus ();

  note_hit_detector #(
    .LANES(LANES), .X_W(X_W), .PY_W(PY_W), .NY_W(NY_W), .SZ_W(SZ_W),
    .HIT_LINE(400), .HIT_WIN(16), .STREAK_W(STREAK_W), .CNT_W(CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.pix_valid_out) begin
        vecs++;
        if (pix_q.size() == 0) begin
          errs++;
          $display("FAIL pix_unexpected: got pix_valid_out=1 in_note=%b at cycle %0d, required no output",
                   bus.in_note, cyc);
        end else begin
          pix_exp_t e;
          e = pix_q.pop_front();
          if (bus.in_note !== e.in_note || bus.any_in_note !== e.any ||
              bus.lane_idx !== e.idx || cyc != e.due) begin
            errs++;
            $display("FAIL pix_result: got in_note=%b any=%b idx=%0d cyc=%0d, required in_note=%b any=%b idx=%0d cyc=%0d",
                     bus.in_note, bus.any_in_note, bus.lane_idx, cyc, e.in_note, e.any, e.idx, e.due);
          end
        end
      end else begin
        vecs++;
        if (bus.in_note !== '0 || bus.any_in_note !== 1'b0 || bus.lane_idx !== 3'd0) begin
          errs++;
          $display("FAIL pix_bubble: got in_note=%b any=%b idx=%0d, required all zero",
                   bus.in_note, bus.any_in_note, bus.lane_idx);
        end
        if (pix_q.size() != 0 && pix_q[0].due < cyc) begin
          errs++;
          $display("FAIL pix_late: got no output by cycle %0d, required output at cycle %0d", cyc, pix_q[0].due);
          void'(pix_q.pop_front());
        end
      end

      if ((bus.hit_pulse | bus.miss_pulse) != '0) begin
        vecs++;
        if (jud_q.size() == 0) begin
          errs++;
          $display("FAIL judge_unexpected: got hit=%b miss=%b at cycle %0d, required no pulse",
                   bus.hit_pulse, bus.miss_pulse, cyc);
        end else begin
          jud_exp_t j;
          j = jud_q.pop_front();
          if (bus.hit_pulse !== j.hit || bus.miss_pulse !== j.miss || bus.streak !== j.streak ||
              bus.hit_count !== j.cnt || cyc != j.due) begin
            errs++;
            $display("FAIL judge: got hit=%b miss=%b streak=%0d count=%0d cyc=%0d, required hit=%b miss=%b streak=%0d count=%0d cyc=%0d",
                     bus.hit_pulse, bus.miss_pulse, bus.streak, bus.hit_count, cyc,
                     j.hit, j.miss, j.streak, j.cnt, j.due);
          end
        end
      end else if (jud_q.size() != 0 && jud_q[0].due < cyc) begin
        vecs++;
        errs++;
        $display("FAIL judge_late: got no pulse by cycle %0d, required pulse at cycle %0d", cyc, jud_q[0].due);
        void'(jud_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic set_lane(input int i, input int x, input int ny, input int w, input logic act);
    bus.note_x[i*X_W +: X_W]        = X_W'(x);
    bus.note_y[i*NY_W +: NY_W]      = {PY_W'(ny), 12'hABC};
    bus.note_width[i*SZ_W +: SZ_W]  = SZ_W'(w);
    bus.note_active[i]              = act;
  endtask

  task automatic send_pix(input int x, input int y, input logic [LANES-1:0] exp_in, input logic [2:0] exp_idx);
    pix_exp_t e;
    bus.pix_valid = 1'b1;
    bus.curr_x    = X_W'(x);
    bus.curr_y    = PY_W'(y);
    e.in_note = exp_in;
    e.any     = |exp_in;
    e.idx     = exp_idx;
    e.due     = cyc + 2;
    pix_q.push_back(e);
    @(posedge clock); #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic do_strum(input logic [LANES-1:0] s, input logic [LANES-1:0] eh, input logic [LANES-1:0] em,
                          input int es, input int ec);
    jud_exp_t j;
    bus.strum = s;
    j.hit    = eh;
    j.miss   = em;
    j.streak = STREAK_W'(es);
    j.cnt    = CNT_W'(ec);
    j.due    = cyc + 1;
    jud_q.push_back(j);
    @(posedge clock); #1;
    bus.strum = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic check_all_zero(input string name);
    vecs++;
    if (bus.pix_valid_out !== 1'b0 || bus.in_note !== '0 || bus.any_in_note !== 1'b0 ||
        bus.lane_idx !== 3'd0 || bus.hit_pulse !== '0 || bus.miss_pulse !== '0 ||
        bus.streak !== '0 || bus.hit_count !== '0) begin
      errs++;
      $display("FAIL %s: got pvo=%b in=%b any=%b idx=%0d hit=%b miss=%b streak=%0d cnt=%0d, required all zero",
               name, bus.pix_valid_out, bus.in_note, bus.any_in_note, bus.lane_idx,
               bus.hit_pulse, bus.miss_pulse, bus.streak, bus.hit_count);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int s_exp;
    bus.pix_valid   = 1'b0;
    bus.curr_x      = '0;
    bus.curr_y      = '0;
    bus.note_x      = '0;
    bus.note_y      = '0;
    bus.note_width  = '0;
    bus.note_active = '0;
    bus.strum       = '0;

    repeat (2) @(posedge clock);
    #2;
    check_all_zero("reset_state");
    @(posedge clock); #1;
    reset = 1'b0;

    // Single lane, strict edges
    set_lane(0, 100, 200, 32, 1'b1);
    send_pix(101, 201, 5'b00001, 3'd0);
    send_pix(131, 231, 5'b00001, 3'd0);
    idle(1);
    send_pix(100, 210, 5'b00000, 3'd0);
    send_pix(132, 210, 5'b00000, 3'd0);

    // Overlapping lanes and priority
    set_lane(1, 290, 90, 20, 1'b1);
    set_lane(3, 295, 95, 10, 1'b1);
    send_pix(300, 100, 5'b01010, 3'd1);
    bus.note_active[1] = 1'b0;
    send_pix(300, 100, 5'b01000, 3'd3);

    // Right-edge clipping, no wrap to x=0
    set_lane(4, 1020, 0, 10, 1'b1);
    send_pix(5, 3, 5'b00000, 3'd0);
    send_pix(1022, 3, 5'b10000, 3'd4);
    idle(3);

    // Judge path
    bus.note_active = '0;
    set_lane(2, 0, 384, 32, 1'b1);                    // centre 400
    do_strum(5'b00100, 5'b00100, 5'b00000, 1, 1);
    set_lane(2, 0, 417, 32, 1'b1);                    // centre 433
    do_strum(5'b00100, 5'b00000, 5'b00100, 0, 1);
    set_lane(2, 0, 368, 32, 1'b1);                    // centre 384, distance 16
    do_strum(5'b00100, 5'b00100, 5'b00000, 1, 2);
    set_lane(2, 0, 400, 32, 1'b1);                    // centre 416, distance 16
    do_strum(5'b00100, 5'b00100, 5'b00000, 2, 3);
    set_lane(2, 0, 401, 32, 1'b1);                    // centre 417, distance 17
    do_strum(5'b00100, 5'b00000, 5'b00100, 0, 3);

    // Hit on lane 0 plus strum on inactive lane 4 in the same cycle
    bus.note_active = '0;
    set_lane(0, 100, 384, 32, 1'b1);
    set_lane(4, 1020, 384, 32, 1'b0);
    do_strum(5'b10001, 5'b00001, 5'b10000, 0, 4);

    // Held strum: judged every cycle; streak saturates at 255
    for (int k = 1; k <= 256; k++) begin
      s_exp = (k > 255) ? 255 : k;
      do_strum(5'b00001, 5'b00001, 5'b00000, s_exp, 4 + k);
    end
    idle(2);

    // Asynchronous reset with pixels in flight
    set_lane(0, 100, 200, 32, 1'b1);
    bus.pix_valid = 1'b1; bus.curr_x = 10'd101; bus.curr_y = 9'd201;
    @(posedge clock); #1;
    bus.curr_x = 10'd102; bus.curr_y = 9'd202;
    @(posedge clock); #1;
    bus.pix_valid = 1'b0;
    vecs++;
    if (bus.pix_valid_out !== 1'b1 || bus.in_note !== 5'b00001) begin
      errs++;
      $display("FAIL pre_reset_out: got pvo=%b in_note=%b, required pvo=1 in_note=00001",
               bus.pix_valid_out, bus.in_note);
    end
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    pix_q.delete();
    jud_q.delete();
    @(posedge clock); @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #1;
    idle(4);
    send_pix(101, 201, 5'b00001, 3'd0);
    idle(4);

    vecs++;
    if (pix_q.size() != 0 || jud_q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pixel and %0d judge entries outstanding, required 0 and 0",
               pix_q.size(), jud_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_note_hit_detector
`default_nettype wire

// File: doc/note_hit_detector.md
Name: note_hit_detector

Overview:
- Multi-lane successor to the single-note pixel bounds test in the Guitar Hero display/gameplay path.
- For each VGA pixel, tests the current x/y against up to LANES falling notes in a 2-stage registered pipeline. Reports per-lane coverage plus the highest-priority covering lane for the colour mux.
- Also judges player strums against a hit window around the target line and maintains a streak counter and a total hit counter.

Parameters:
- LANES, 5, number of note lanes (1..8)
- X_W, 10, pixel x width
- PY_W, 9, pixel y width
- NY_W, 21, note y width; unsigned fixed point, integer part is note_y[NY_W-1:NY_W-PY_W]
- SZ_W, 7, note width/height field width (notes are square)
- HIT_LINE, 400, target-line pixel row
- HIT_WIN, 16, allowed half-window in pixels, inclusive
- STREAK_W, 8, streak counter width
- CNT_W, 16, hit counter width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- pix_valid  in  1  curr_x/curr_y valid this cycle
- curr_x  in  X_W  pixel x
- curr_y  in  PY_W  pixel y
- note_x  in  LANES*X_W  lane i at [i*X_W +: X_W]
- note_y  in  LANES*NY_W  lane i at [i*NY_W +: NY_W]
- note_width  in  LANES*SZ_W  per-lane size
- note_active  in  LANES  lane has a live note
- strum  in  LANES  one-cycle strum pulse per lane
- pix_valid_out  out  1  pix_valid delayed 2 cycles
- in_note  out  LANES  pixel strictly inside lane i note (active lanes only)
- any_in_note  out  1  OR of in_note
- lane_idx  out  3  lowest index set in in_note, 0 if none
- hit_pulse  out  LANES  one-cycle hit per lane
- miss_pulse  out  LANES  one-cycle miss per lane
- streak  out  STREAK_W  consecutive-hit count, saturating
- hit_count  out  CNT_W  total hits, saturating

Behaviour:
- Reset (async, immediate): every output 0, pipeline valids 0, counters 0. Reset asserted mid-frame discards in-flight pixels; no stale pix_valid_out after release.
- Pixel path, latency 2:
  - Stage 1 registers per-lane compares with curr_y integer part ny = note_y[NY_W-1:NY_W-PY_W].
  - Lane condition: curr_x > note_x AND curr_x < note_x+w AND curr_y > ny AND curr_y < ny+w. All strict, so edge pixels are outside.
  - Sums are computed at width+1 so note_x+w never wraps. A note near x=1023 clips; it does not alias to x=0.
  - A lane with note_active=0 is forced 0.
  - Stage 2 registers in_note, any_in_note and lane_idx via a priority encoder, and asserts pix_valid_out.
  - When a stage holds a bubble (pix_valid=0), in_note/any_in_note/lane_idx for that slot are 0.
  - The pipeline never stalls; one pixel per cycle.
- Judge path, latency 1 from strum:
  - centre = ny + (w>>1), computed at PY_W+1 bits.
  - Hit if note_active[i] and |centre − HIT_LINE| ≤ HIT_WIN. Otherwise miss, including strum on an inactive lane.
  - hit_pulse[i]/miss_pulse[i] are high for exactly one cycle, the cycle after strum[i]. hit and miss are mutually exclusive per lane.
- Counters update on the same edge as the pulses:
  - Any miss in a cycle: streak = 0, and hits in that same cycle do not add to streak. hit_count still adds those hits.
  - Otherwise: streak += popcount(hits), saturating at all-ones.
  - hit_count += popcount(hits), saturating at all-ones.
- strum held high for k cycles is judged k times; debouncing is upstream.
- The pixel path and the judge path are independent; simultaneous activity does not interact.

Decomposition:
- Package note_pkg: lane-slice index helpers, HIT_LINE/HIT_WIN defaults, lane_idx width constant.
- Sub-module lane_bounds: one lane's four strict compares plus the centre/window test, purely combinational. Instantiate LANES times via generate. Pipeline registers, priority encoder and counters stay in the top.

Test Plan:
- Lane0 note_x=100, ny=200, w=32, active; pixels (101,201), (131,231), (100,210), (132,210) -> in_note[0]=1,1,0,0, each exactly 2 cycles after its input, with pix_valid_out aligned.
- Lanes 1 and 3 both cover pixel (300,100) -> in_note=01010b, any_in_note=1, lane_idx=1. Drop note_active[1] -> lane_idx=3.
- note_x=1020, w=10, pixel x=5 -> in_note=0, proving no wrap.
- Lane2 ny=384, w=32 (centre 400), strum[2] -> hit_pulse[2] one cycle, streak 0→1, hit_count 1. ny=417 (centre 433) -> miss_pulse[2], streak 0, hit_count unchanged.
- Same cycle: strum lanes 0 (hit) and 4 (inactive) -> hit_pulse=00001b, miss_pulse=10000b, streak=0, hit_count+1. Streak at 255 plus 1 hit -> stays 255.
- Assert reset asynchronously between clock edges with pixels in flight -> all outputs 0 immediately; the first pix_valid_out after release comes 2 cycles after the next pix_valid.
